// File: rtl/ruby_lsu_l1d_req_arb.sv
// LSU-to-L1D request arbiter: round-robin grant into a request FIFO,
// outstanding-request throttle, and registered one-hot response routing.
module ruby_lsu_l1d_req_arb #(
    parameter int N_PORT  = 2,
    parameter int DEPTH   = 4,
    parameter int ID_W    = 4,
    parameter int OP_W    = 6,
    parameter int PADDR_W = 56,
    parameter int XLEN    = 64,
    parameter int MAX_OUT = 8,
    localparam int PW     = (N_PORT > 1) ? $clog2(N_PORT) : 1,
    localparam int TW     = PW + ID_W,
    localparam int OW     = $clog2(MAX_OUT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic [N_PORT-1:0]         req_vld_i,
    output logic [N_PORT-1:0]         req_rdy_o,
    input  logic [N_PORT*ID_W-1:0]    req_id_i,
    input  logic [N_PORT*OP_W-1:0]    req_op_i,
    input  logic [N_PORT*PADDR_W-1:0] req_paddr_i,
    input  logic [N_PORT*XLEN-1:0]    req_dat_i,
    input  logic [N_PORT-1:0]         req_cacheable_i,
    output logic                      l1d_req_vld_o,
    input  logic                      l1d_req_rdy_i,
    output logic [TW-1:0]             l1d_req_id_o,
    output logic [OP_W-1:0]           l1d_req_op_o,
    output logic [PADDR_W-1:0]        l1d_req_paddr_o,
    output logic [XLEN-1:0]           l1d_req_dat_o,
    output logic                      l1d_req_cacheable_o,
    input  logic                      l1d_resp_vld_i,
    input  logic [TW-1:0]             l1d_resp_id_i,
    input  logic [XLEN-1:0]           l1d_resp_dat_i,
    input  logic                      l1d_resp_err_i,
    output logic [N_PORT-1:0]         resp_vld_o,
    output logic [ID_W-1:0]           resp_id_o,
    output logic [XLEN-1:0]           resp_dat_o,
    output logic                      resp_err_o,
    output logic [OW-1:0]             outstanding_o
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [TW-1:0]      tag;
        logic [OP_W-1:0]    op;
        logic [PADDR_W-1:0] paddr;
        logic [XLEN-1:0]    dat;
        logic               cacheable;
    } ent_t;

    ent_t            mem [DEPTH];
    ent_t            wr_ent;
    ent_t            head;
    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     cnt;
    logic [PW-1:0]   rr_ptr, gnt_idx;
    logic            gnt_any, full, push, pop;
    logic [PW-1:0]   rport;

    // Lowest offset from rr_ptr wins: scan downward so the last hit is the nearest.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = N_PORT - 1; i >= 0; i--) begin
            if (req_vld_i[(int'(rr_ptr) + i) % N_PORT]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'((int'(rr_ptr) + i) % N_PORT);
            end
        end
    end

    assign full = (cnt == (AW+1)'(DEPTH));
    assign pop  = l1d_req_vld_o && l1d_req_rdy_i;
    // A full queue may still accept when the head leaves in the same cycle.
    assign push = gnt_any && !flush_i && !rst && (!full || pop);
    assign req_rdy_o = push ? (N_PORT'(1) << gnt_idx) : '0;

    always_comb begin
        wr_ent.tag       = {gnt_idx, req_id_i[int'(gnt_idx)*ID_W +: ID_W]};
        wr_ent.op        = req_op_i[int'(gnt_idx)*OP_W +: OP_W];
        wr_ent.paddr     = req_paddr_i[int'(gnt_idx)*PADDR_W +: PADDR_W];
        wr_ent.dat       = req_dat_i[int'(gnt_idx)*XLEN +: XLEN];
        wr_ent.cacheable = req_cacheable_i[gnt_idx];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_ent;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr   <= wptr + 1'b1;
                rr_ptr <= (int'(gnt_idx) == N_PORT - 1) ? '0 : gnt_idx + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head                = mem[rptr];
    assign l1d_req_vld_o       = (cnt != '0) && (outstanding_o < OW'(MAX_OUT));
    assign l1d_req_id_o        = head.tag;
    assign l1d_req_op_o        = head.op;
    assign l1d_req_paddr_o     = head.paddr;
    assign l1d_req_dat_o       = head.dat;
    assign l1d_req_cacheable_o = head.cacheable;

    // Flush does not touch this: issued requests still owe a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_o <= '0;
        end else begin
            case ({pop, l1d_resp_vld_i})
                2'b10:   outstanding_o <= outstanding_o + 1'b1;
                2'b01:   if (outstanding_o != '0) outstanding_o <= outstanding_o - 1'b1;
                default: outstanding_o <= outstanding_o;
            endcase
        end
    end

    assign rport = l1d_resp_id_i[TW-1:ID_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_vld_o <= '0;
            resp_id_o  <= '0;
            resp_dat_o <= '0;
            resp_err_o <= 1'b0;
        end else begin
            resp_vld_o <= (l1d_resp_vld_i && int'(rport) < N_PORT) ? (N_PORT'(1) << rport) : '0;
            if (l1d_resp_vld_i) begin
                resp_id_o  <= l1d_resp_id_i[ID_W-1:0];
                resp_dat_o <= l1d_resp_dat_i;
                resp_err_o <= l1d_resp_err_i;
            end
        end
    end
endmodule

// File: tb/tb_ruby_lsu_l1d_req_arb.sv
// Directed bench for ruby_lsu_l1d_req_arb: arbitration order, queue depth,
// outstanding throttle, response routing, flush and mid-run reset.
module tb_ruby_lsu_l1d_req_arb;
    localparam int N_PORT = 2, DEPTH = 4, ID_W = 4, OP_W = 6, PADDR_W = 56;
    localparam int XLEN = 64, MAX_OUT = 8, PW = 1, TW = 5, OW = 4;

    logic                      clk, rst, flush_i;
    logic [N_PORT-1:0]         req_vld_i, req_rdy_o, req_cacheable_i;
    logic [N_PORT*ID_W-1:0]    req_id_i;
    logic [N_PORT*OP_W-1:0]    req_op_i;
    logic [N_PORT*PADDR_W-1:0] req_paddr_i;
    logic [N_PORT*XLEN-1:0]    req_dat_i;
    logic                      l1d_req_vld_o, l1d_req_rdy_i, l1d_req_cacheable_o;
    logic [TW-1:0]             l1d_req_id_o;
    logic [OP_W-1:0]           l1d_req_op_o;
    logic [PADDR_W-1:0]        l1d_req_paddr_o;
    logic [XLEN-1:0]           l1d_req_dat_o;
    logic                      l1d_resp_vld_i, l1d_resp_err_i;
    logic [TW-1:0]             l1d_resp_id_i;
    logic [XLEN-1:0]           l1d_resp_dat_i;
    logic [N_PORT-1:0]         resp_vld_o;
    logic [ID_W-1:0]           resp_id_o;
    logic [XLEN-1:0]           resp_dat_o;
    logic                      resp_err_o;
    logic [OW-1:0]             outstanding_o;

    ruby_lsu_l1d_req_arb #(
        .N_PORT(N_PORT), .DEPTH(DEPTH), .ID_W(ID_W), .OP_W(OP_W),
        .PADDR_W(PADDR_W), .XLEN(XLEN), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_id_i(req_id_i),
        .req_op_i(req_op_i), .req_paddr_i(req_paddr_i), .req_dat_i(req_dat_i),
        .req_cacheable_i(req_cacheable_i),
        .l1d_req_vld_o(l1d_req_vld_o), .l1d_req_rdy_i(l1d_req_rdy_i),
        .l1d_req_id_o(l1d_req_id_o), .l1d_req_op_o(l1d_req_op_o),
        .l1d_req_paddr_o(l1d_req_paddr_o), .l1d_req_dat_o(l1d_req_dat_o),
        .l1d_req_cacheable_o(l1d_req_cacheable_o),
        .l1d_resp_vld_i(l1d_resp_vld_i), .l1d_resp_id_i(l1d_resp_id_i),
        .l1d_resp_dat_i(l1d_resp_dat_i), .l1d_resp_err_i(l1d_resp_err_i),
        .resp_vld_o(resp_vld_o), .resp_id_o(resp_id_o), .resp_dat_o(resp_dat_o),
        .resp_err_o(resp_err_o), .outstanding_o(outstanding_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_resp(input logic vld, input logic [TW-1:0] tag,
                            input logic [XLEN-1:0] dat, input logic err);
        l1d_resp_vld_i = vld;
        l1d_resp_id_i  = tag;
        l1d_resp_dat_i = dat;
        l1d_resp_err_i = err;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int acc, hs;
        rst = 1'b1; flush_i = 1'b0; req_vld_i = '0; l1d_req_rdy_i = 1'b0;
        req_id_i = {4'h2, 4'h1}; req_op_i = {6'h2, 6'h1};
        req_paddr_i = {56'h200, 56'h100}; req_dat_i = {64'h22, 64'h11};
        req_cacheable_i = 2'b01;
        set_resp(1'b0, '0, '0, 1'b0);

        // reset state, including rdy held low despite valid requests
        cyc(); req_vld_i = 2'b11; cyc(); #2;
        chk("rst_req_rdy", req_rdy_o, 0);
        chk("rst_l1d_vld", l1d_req_vld_o, 0);
        chk("rst_resp_vld", resp_vld_o, 0);
        chk("rst_resp_id", resp_id_o, 0);
        chk("rst_resp_dat", resp_dat_o, 0);
        chk("rst_resp_err", resp_err_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        req_vld_i = '0;
        rst = 1'b0;
        cyc();

        // round-robin alternation and one-cycle FIFO latency
        req_vld_i = 2'b11; l1d_req_rdy_i = 1'b1; #2;
        chk("rr_first_latency", l1d_req_vld_o, 0);
        chk("rr_grant0", req_rdy_o, 2'b01);
        for (int t = 1; t < 4; t++) begin
            cyc(); #2;
            chk("rr_grant", req_rdy_o, (t % 2) ? 2'b10 : 2'b01);
            chk("rr_head_tag", l1d_req_id_o, ((t - 1) % 2) ? 5'h12 : 5'h01);
        end
        cyc(); #2;
        chk("rr_head_tag_last", l1d_req_id_o, 5'h12);
        chk("rr_head_paddr", l1d_req_paddr_o, 56'h200);
        req_vld_i = '0;
        cyc(); #2;
        chk("rr_outstanding", outstanding_o, 4);
        chk("rr_drained", l1d_req_vld_o, 0);

        // response routing, then saturation at zero
        set_resp(1'b1, {1'b1, 4'hA}, 64'hDEAD_BEEF, 1'b1);
        cyc(); #2;
        chk("resp1_vld", resp_vld_o, 2'b10);
        chk("resp1_id", resp_id_o, 4'hA);
        chk("resp1_dat", resp_dat_o, 64'hDEAD_BEEF);
        chk("resp1_err", resp_err_o, 1);
        chk("resp1_outstanding", outstanding_o, 3);
        set_resp(1'b1, {1'b0, 4'h3}, 64'h55, 1'b0);
        cyc(); #2;
        chk("resp2_vld", resp_vld_o, 2'b01);
        chk("resp2_id", resp_id_o, 4'h3);
        chk("resp2_err", resp_err_o, 0);
        chk("resp2_outstanding", outstanding_o, 2);
        cyc(); cyc(); #2;
        chk("resp_outstanding_zero", outstanding_o, 0);
        cyc(); #2;
        chk("resp_sat_outstanding", outstanding_o, 0);
        chk("resp_sat_routed", resp_vld_o, 2'b01);
        set_resp(1'b0, '0, '0, 1'b0);
        cyc(); #2;
        chk("resp_idle", resp_vld_o, 0);

        // queue fills at DEPTH; one L1D ready cycle admits exactly one more
        req_vld_i = 2'b01; l1d_req_rdy_i = 1'b0; acc = 0;
        repeat (6) begin #2; if (req_rdy_o[0]) acc++; cyc(); end
        chk("full_accepts", acc, 4);
        #2;
        chk("full_rdy_low", req_rdy_o, 0);
        chk("full_l1d_vld", l1d_req_vld_o, 1);
        cyc();
        l1d_req_rdy_i = 1'b1; acc = 0;
        #2; if (req_rdy_o[0]) acc++;
        cyc();
        l1d_req_rdy_i = 1'b0;
        repeat (3) begin #2; if (req_rdy_o[0]) acc++; cyc(); end
        chk("full_one_more", acc, 1);
        chk("full_outstanding", outstanding_o, 1);

        // throttle at MAX_OUT; one response frees exactly one issue
        l1d_req_rdy_i = 1'b1;
        repeat (7) cyc();
        #2;
        chk("max_outstanding", outstanding_o, 8);
        chk("max_l1d_vld_low", l1d_req_vld_o, 0);
        chk("max_queue_full", req_rdy_o, 0);
        req_vld_i = '0;
        set_resp(1'b1, {1'b0, 4'h1}, 64'h1, 1'b0);
        cyc();
        set_resp(1'b0, '0, '0, 1'b0);
        hs = 0;
        repeat (4) begin #2; if (l1d_req_vld_o && l1d_req_rdy_i) hs++; cyc(); end
        chk("max_one_issue", hs, 1);
        chk("max_outstanding_again", outstanding_o, 8);

        // flush with 3 queued / 2 outstanding
        l1d_req_rdy_i = 1'b0;
        set_resp(1'b1, {1'b0, 4'h5}, 64'h5, 1'b0);
        repeat (6) cyc();
        set_resp(1'b0, '0, '0, 1'b0);
        #2;
        chk("pre_flush_outstanding", outstanding_o, 2);
        chk("pre_flush_l1d_vld", l1d_req_vld_o, 1);
        flush_i = 1'b1; req_vld_i = 2'b01; #2;
        chk("flush_blocks_accept", req_rdy_o, 0);
        cyc();
        flush_i = 1'b0; req_vld_i = '0; #2;
        chk("flush_empty", l1d_req_vld_o, 0);
        chk("flush_outstanding", outstanding_o, 2);
        set_resp(1'b1, {1'b1, 4'h6}, 64'h6, 1'b0);
        cyc(); cyc();
        set_resp(1'b0, '0, '0, 1'b0);
        #2;
        chk("flush_drain_outstanding", outstanding_o, 0);

        // reset mid-operation drops queue and pending response
        req_vld_i = 2'b01;
        cyc(); cyc();
        req_vld_i = '0;
        set_resp(1'b1, {1'b1, 4'h7}, 64'h7, 1'b1);
        cyc();
        set_resp(1'b0, '0, '0, 1'b0);
        #2;
        chk("midrst_pre_resp", resp_vld_o, 2'b10);
        chk("midrst_pre_l1d", l1d_req_vld_o, 1);
        rst = 1'b1; #1;
        chk("midrst_resp_vld", resp_vld_o, 0);
        chk("midrst_resp_id", resp_id_o, 0);
        chk("midrst_l1d_vld", l1d_req_vld_o, 0);
        chk("midrst_outstanding", outstanding_o, 0);
        cyc();
        rst = 1'b0;
        cyc(); #2;
        chk("midrst_queue_empty", l1d_req_vld_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
